// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one byte-wide synchronous RAM port between IF and MEM.
// Optional one-entry fetch buffer: define MEM_ARB_IF_BUF_EN.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic        sel_mem;

  logic [31:0] word_nxt;
  logic [31:0] addr_nxt;
  logic [7:0]  wbyte_nxt;
  logic [2:0]  mem_len_dec;

`ifdef MEM_ARB_IF_BUF_EN
  logic        buf_vld;
  logic        buf_hit;
  logic [31:0] buf_addr;
  logic [31:0] buf_word;
`endif

  always_comb begin
    case (mem_len_i)
      2'b00:   mem_len_dec = 3'd1;
      2'b01:   mem_len_dec = 3'd2;
      default: mem_len_dec = 3'd4;
    endcase
  end

  // ram_din_i carries the byte for the address presented last cycle, i.e. lane cnt-1
  always_comb begin
    word_nxt = rbuf;
    case (cnt)
      3'd1:    word_nxt[7:0]   = ram_din_i;
      3'd2:    word_nxt[15:8]  = ram_din_i;
      3'd3:    word_nxt[23:16] = ram_din_i;
      3'd4:    word_nxt[31:24] = ram_din_i;
      default: word_nxt        = rbuf;
    endcase
  end

  always_comb begin
    case (cnt)
      3'd0:    wbyte_nxt = wdata[15:8];
      3'd1:    wbyte_nxt = wdata[23:16];
      3'd2:    wbyte_nxt = wdata[31:24];
      default: wbyte_nxt = 8'h00;
    endcase
  end

  assign addr_nxt    = base + {29'd0, cnt} + 32'd1;
  assign stall_req_o = (mem_req_i & ~mem_ack_o) | (if_req_i & ~if_ack_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= 32'd0;
      wdata       <= 32'd0;
      rbuf        <= 32'd0;
      cnt         <= 3'd0;
      len         <= 3'd0;
      sel_mem     <= 1'b0;
      if_ack_o    <= 1'b0;
      if_data_o   <= 32'd0;
      mem_ack_o   <= 1'b0;
      mem_rdata_o <= 32'd0;
      ram_a_o     <= 32'd0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
`ifdef MEM_ARB_IF_BUF_EN
      buf_vld     <= 1'b0;
      buf_hit     <= 1'b0;
      buf_addr    <= 32'd0;
      buf_word    <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            sel_mem <= 1'b1;
            base    <= mem_addr_i;
            len     <= mem_len_dec;
            wdata   <= mem_wdata_i;
            cnt     <= 3'd0;
            rbuf    <= 32'd0;
            ram_a_o <= mem_addr_i;
            if (mem_we_i) begin
              ram_wr_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
              state      <= WRITE;
`ifdef MEM_ARB_IF_BUF_EN
              buf_vld    <= 1'b0;
`endif
            end else begin
              state <= READ;
            end
          end else if (if_req_i) begin
            sel_mem <= 1'b0;
            base    <= if_addr_i;
            len     <= 3'd4;
            cnt     <= 3'd0;
            rbuf    <= 32'd0;
            state   <= READ;
`ifdef MEM_ARB_IF_BUF_EN
            // a hit spends one cycle in READ without driving the RAM port
            if (buf_vld && buf_addr == if_addr_i) buf_hit <= 1'b1;
            else                                  ram_a_o <= if_addr_i;
`else
            ram_a_o <= if_addr_i;
`endif
          end
        end
        READ: begin
`ifdef MEM_ARB_IF_BUF_EN
          if (buf_hit) begin
            buf_hit   <= 1'b0;
            if_ack_o  <= 1'b1;
            if_data_o <= buf_word;
            state     <= DONE;
          end else
`endif
          begin
            rbuf <= word_nxt;
            cnt  <= cnt + 3'd1;
            if (cnt + 3'd1 < len) ram_a_o <= addr_nxt;
            if (cnt == len) begin
              state <= DONE;
              if (sel_mem) begin
                mem_ack_o   <= 1'b1;
                mem_rdata_o <= word_nxt;
              end else begin
                if_ack_o  <= 1'b1;
                if_data_o <= word_nxt;
`ifdef MEM_ARB_IF_BUF_EN
                buf_vld   <= 1'b1;
                buf_addr  <= base;
                buf_word  <= word_nxt;
`endif
              end
            end
          end
        end
        WRITE: begin
          if (cnt + 3'd1 < len) begin
            cnt        <= cnt + 3'd1;
            ram_a_o    <= addr_nxt;
            ram_dout_o <= wbyte_nxt;
          end else begin
            ram_wr_o  <= 1'b0;
            mem_ack_o <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          if_ack_o  <= 1'b0;
          mem_ack_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, mem_req, mem_we, mem_ack, ram_wr, stall;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_a;
  logic [1:0]  mem_len;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  ram [0:1023];

  logic [31:0] t_a     [0:31];
  logic        t_wr    [0:31];
  logic [7:0]  t_dout  [0:31];
  logic        t_ifa   [0:31];
  logic        t_mema  [0:31];
  logic        t_stall [0:31];
  logic [31:0] t_ifd   [0:31];
  logic [31:0] t_memd  [0:31];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_din <= ram[ram_a[9:0]];
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
  end

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata),
    .ram_a_o(ram_a), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout), .ram_din_i(ram_din),
    .stall_req_o(stall)
  );

  task automatic sample(input int c);
    t_a[c] = ram_a; t_wr[c] = ram_wr; t_dout[c] = ram_dout; t_ifa[c] = if_ack;
    t_mema[c] = mem_ack; t_stall[c] = stall; t_ifd[c] = if_data; t_memd[c] = mem_rdata;
  endtask

  // Cycle 0 is the cycle in which the request is first presented.
  task automatic run(input int n, input int rst_at);
    #1 sample(0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (t_ifa[c-1])  if_req  = 1'b0;
      if (t_mema[c-1]) mem_req = 1'b0;
      if (c == rst_at) begin rst = 1'b1; mem_req = 1'b0; if_req = 1'b0; end
      else if (c == rst_at + 1) rst = 1'b0;
      #1 sample(c);
    end
  endtask

  function automatic int first_cyc(input logic v [0:31], input int n);
    for (int c = 0; c <= n; c++) if (v[c]) return c;
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({if_ack, mem_ack, ram_wr, stall} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctl got %b want 0000", {if_ack, mem_ack, ram_wr, stall});
    end
    n_cmp++;
    if ({ram_a, ram_dout, if_data, mem_rdata} !== 104'd0) begin
      n_bad++; $display("FAIL reset_data a=%h dout=%h ifd=%h memd=%h want 0", ram_a, ram_dout, if_data, mem_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch;
    int ca;
    ram[16] <= 8'h13; ram[17] <= 8'h37; ram[18] <= 8'h00; ram[19] <= 8'hFF;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    run(8, -1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (t_a[i+1] !== 32'h10 + i) begin
        n_bad++; $display("FAIL fetch_addr cyc %0d got %h want %h", i+1, t_a[i+1], 32'h10 + i);
      end
    end
    ca = first_cyc(t_ifa, 8);
    n_cmp++;
    if (ca !== 6) begin n_bad++; $display("FAIL fetch_ack_cyc got %0d want 6", ca); end
    n_cmp++;
    if (t_ifd[6] !== 32'hFF003713) begin n_bad++; $display("FAIL fetch_data got %h want FF003713", t_ifd[6]); end
    n_cmp++;
    if (t_ifa[7] !== 1'b0) begin n_bad++; $display("FAIL fetch_ack_width got %b want 0", t_ifa[7]); end
    n_cmp++;
    if ({t_stall[0], t_stall[5], t_stall[6], t_stall[7]} !== 4'b1100) begin
      n_bad++; $display("FAIL fetch_stall got %b want 1100", {t_stall[0], t_stall[5], t_stall[6], t_stall[7]});
    end
  endtask

  task automatic test_store;
    int ca;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
    run(8, -1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({t_wr[i+1], t_a[i+1], t_dout[i+1]} !== {1'b1, 32'h100 + i, exp_b[i]}) begin
        n_bad++; $display("FAIL store_beat cyc %0d got wr=%b a=%h d=%h want 1 %h %h",
                          i+1, t_wr[i+1], t_a[i+1], t_dout[i+1], 32'h100 + i, exp_b[i]);
      end
    end
    n_cmp++;
    if (t_wr[5] !== 1'b0) begin n_bad++; $display("FAIL store_wr_end got %b want 0", t_wr[5]); end
    ca = first_cyc(t_mema, 8);
    n_cmp++;
    if (ca !== 5) begin n_bad++; $display("FAIL store_ack_cyc got %0d want 5", ca); end
    n_cmp++;
    if (t_stall[6] !== 1'b0) begin n_bad++; $display("FAIL store_stall6 got %b want 0", t_stall[6]); end
    n_cmp++;
    if ({ram[259], ram[258], ram[257], ram[256]} !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL store_ram got %h want DEADBEEF", {ram[259], ram[258], ram[257], ram[256]});
    end
    mem_we = 1'b0;
  endtask

  task automatic test_priority;
    int cm, ci;
    ram[32] <= 8'h5A;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h10;
    run(12, -1);
    cm = first_cyc(t_mema, 12);
    ci = first_cyc(t_ifa, 12);
    n_cmp++;
    if (cm !== 3) begin n_bad++; $display("FAIL prio_mem_ack got %0d want 3", cm); end
    n_cmp++;
    if (t_memd[3] !== 32'h0000005A) begin n_bad++; $display("FAIL prio_mem_data got %h want 0000005A", t_memd[3]); end
    n_cmp++;
    if (t_ifd[3] !== 32'hFF003713) begin n_bad++; $display("FAIL prio_if_hold got %h want FF003713", t_ifd[3]); end
    n_cmp++;
    if ({t_a[1], t_a[5], t_a[8]} !== {32'h20, 32'h10, 32'h13}) begin
      n_bad++; $display("FAIL prio_addr got %h %h %h want 20 10 13", t_a[1], t_a[5], t_a[8]);
    end
    n_cmp++;
    if (ci !== 10) begin n_bad++; $display("FAIL prio_if_ack got %0d want 10", ci); end
    n_cmp++;
    if (t_memd[10] !== 32'h0000005A) begin n_bad++; $display("FAIL prio_mem_hold got %h want 0000005A", t_memd[10]); end
  endtask

  task automatic test_wrap;
    int ca;
    logic [31:0] exp_a [0:3];
    exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    ram[1022] <= 8'h11; ram[1023] <= 8'h22; ram[0] <= 8'h33; ram[1] <= 8'h44;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b11; mem_addr = 32'hFFFFFFFE;
    run(8, -1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (t_a[i+1] !== exp_a[i]) begin
        n_bad++; $display("FAIL wrap_addr cyc %0d got %h want %h", i+1, t_a[i+1], exp_a[i]);
      end
    end
    ca = first_cyc(t_mema, 8);
    n_cmp++;
    if (ca !== 6 || t_memd[6] !== 32'h44332211) begin
      n_bad++; $display("FAIL wrap_data cyc %0d got %h want cyc 6 44332211", ca, t_memd[6]);
    end
  endtask

  task automatic test_lengths;
    int ca;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h11;
    run(7, -1);
    ca = first_cyc(t_mema, 7);
    n_cmp++;
    if (ca !== 4 || t_memd[4] !== 32'h00000037) begin
      n_bad++; $display("FAIL half_load cyc %0d got %h want cyc 4 00000037", ca, t_memd[4]);
    end
    mem_req = 1'b1; mem_len = 2'b00; mem_addr = 32'h13;
    run(6, -1);
    ca = first_cyc(t_mema, 6);
    n_cmp++;
    if (ca !== 3 || t_memd[3] !== 32'h000000FF) begin
      n_bad++; $display("FAIL byte_zext cyc %0d got %h want cyc 3 000000FF", ca, t_memd[3]);
    end
  endtask

  task automatic test_reset_mid;
    int ca;
    ram[514] <= 8'h00;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    run(10, 2);
    n_cmp++;
    if ({t_wr[1], t_wr[2], t_wr[3]} !== 3'b110) begin
      n_bad++; $display("FAIL rstmid_wr got %b want 110", {t_wr[1], t_wr[2], t_wr[3]});
    end
    n_cmp++;
    if (t_a[3] !== 32'h0) begin n_bad++; $display("FAIL rstmid_addr got %h want 0", t_a[3]); end
    ca = first_cyc(t_mema, 10);
    n_cmp++;
    if (ca !== -1) begin n_bad++; $display("FAIL rstmid_noack got ack at %0d want none", ca); end
    ca = first_cyc(t_wr, 10);
    n_cmp++;
    if (t_wr[10] !== 1'b0 || t_a[10] !== 32'h0 || t_stall[10] !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_idle got wr=%b a=%h stall=%b want 0 0 0", t_wr[10], t_a[10], t_stall[10]);
    end
    n_cmp++;
    if ({ram[514], ram[512]} !== 16'h00EF) begin
      n_bad++; $display("FAIL rstmid_ram got %h want 00EF", {ram[514], ram[512]});
    end
    mem_we = 1'b0;
  endtask

`ifdef MEM_ARB_IF_BUF_EN
  task automatic test_fetch_buf;
    int ca;
    if_req = 1'b1; if_addr = 32'h10;
    run(8, -1);
    ca = first_cyc(t_ifa, 8);
    n_cmp++;
    if (ca !== 6) begin n_bad++; $display("FAIL buf_fill_ack got %0d want 6", ca); end
    if_req = 1'b1; if_addr = 32'h10;
    run(5, -1);
    ca = first_cyc(t_ifa, 5);
    n_cmp++;
    if (ca !== 2 || t_ifd[2] !== 32'hFF003713) begin
      n_bad++; $display("FAIL buf_hit cyc %0d data %h want cyc 2 FF003713", ca, t_ifd[2]);
    end
    n_cmp++;
    if (t_a[1] !== t_a[0] || t_a[3] !== t_a[0] || t_wr[1] !== 1'b0) begin
      n_bad++; $display("FAIL buf_hit_noram a %h %h %h wr %b want unchanged, wr 0", t_a[0], t_a[1], t_a[3], t_wr[1]);
    end
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h300; mem_wdata = 32'h77;
    run(5, -1);
    mem_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    run(8, -1);
    ca = first_cyc(t_ifa, 8);
    n_cmp++;
    if (ca !== 6) begin n_bad++; $display("FAIL buf_inval_ack got %0d want 6", ca); end
  endtask
`endif

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    repeat (2) @(posedge clk);
    test_reset;
    test_fetch;
    test_store;
    test_priority;
    test_wrap;
    test_lengths;
    test_reset_mid;
`ifdef MEM_ARB_IF_BUF_EN
    test_fetch_buf;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
